// File: rtl/grid_step_sequencer.sv
// Timestep controller for the physics-accelerator cell grid: issues clear/load/shift
// strobes, spaces shifts by a settle gap, and optionally hands off a snapshot per step.
module grid_step_sequencer #(
    parameter int STEP_W     = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_init_load,
    input  logic [STEP_W-1:0] i_num_steps,
    input  logic              i_abort,
    input  logic              i_snap_en,
    input  logic              i_snap_ready,
    output logic              o_cell_reset,
    output logic              o_cell_load,
    output logic              o_cell_shift,
    output logic              o_snap_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [STEP_W-1:0] o_step_count
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SHIFT  = 3'd4;
    localparam logic [2:0] S_SNAP   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [CNT_W-1:0]  r_settle_cnt;
    logic [STEP_W-1:0] r_step_count;
    logic [STEP_W-1:0] r_num_steps;
    logic              r_snap_en;
    logic [STEP_W-1:0] w_count_inc;

    // The count never exceeds num_steps, so this increment cannot overflow.
    assign w_count_inc = r_step_count + 1'b1;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_init_load)
                        w_next_state = S_CLEAR;
                    else if (i_num_steps == '0)
                        w_next_state = S_DONE;
                    else
                        w_next_state = S_SETTLE;
                end
            end
            S_CLEAR:  w_next_state = S_LOAD;
            S_LOAD:   w_next_state = (r_num_steps == '0) ? S_DONE : S_SETTLE;
            S_SETTLE: w_next_state = (r_settle_cnt == '0) ? S_SHIFT : S_SETTLE;
            S_SHIFT: begin
                if (r_snap_en)
                    w_next_state = S_SNAP;
                else if (w_count_inc == r_num_steps)
                    w_next_state = S_DONE;
                else
                    w_next_state = S_SETTLE;
            end
            S_SNAP: begin
                if (i_snap_ready)
                    w_next_state = (r_step_count == r_num_steps) ? S_DONE : S_SETTLE;
            end
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        // Abort wins over every other transition out of a busy state.
        if (i_abort && (r_state != S_IDLE))
            w_next_state = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= SETTLE_LAST;
            r_step_count <= '0;
            r_num_steps  <= '0;
            r_snap_en    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_SETTLE) begin
                if (r_settle_cnt != '0)
                    r_settle_cnt <= r_settle_cnt - 1'b1;
            end else begin
                r_settle_cnt <= SETTLE_LAST;
            end
            if ((r_state == S_IDLE) && i_start) begin
                r_num_steps  <= i_num_steps;
                r_snap_en    <= i_snap_en;
                r_step_count <= '0;
            end else if (r_state == S_SHIFT) begin
                r_step_count <= w_count_inc;
            end
        end
    end

    assign o_cell_reset = (r_state == S_CLEAR);
    assign o_cell_load  = (r_state == S_LOAD);
    assign o_cell_shift = (r_state == S_SHIFT);
    assign o_snap_valid = (r_state == S_SNAP);
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_step_count = r_step_count;

endmodule

// File: tb/tb_grid_step_sequencer.sv
// Self-checking bench for grid_step_sequencer: a per-cycle vector table plus
// hand-written snapshot, abort and back-to-back sequences.
module tb_grid_step_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        init_load;
    logic [15:0] num_steps;
    logic        abort;
    logic        snap_en;
    logic        snap_ready;
    logic        cell_reset;
    logic        cell_load;
    logic        cell_shift;
    logic        snap_valid;
    logic        busy;
    logic        done;
    logic [15:0] step_count;

    int total = 0;
    int bad   = 0;

    int nShift = 0;
    int nReset = 0;
    int nLoad  = 0;
    int nDone  = 0;
    int nHs    = 0;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        init_load;
        logic [15:0] num;
        logic [5:0]  expFlags;
        logic [15:0] expCount;
    } vec_t;

    vec_t vecs[$];

    grid_step_sequencer #(.STEP_W(16), .SETTLE_CYC(2)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_init_load  (init_load),
        .i_num_steps  (num_steps),
        .i_abort      (abort),
        .i_snap_en    (snap_en),
        .i_snap_ready (snap_ready),
        .o_cell_reset (cell_reset),
        .o_cell_load  (cell_load),
        .o_cell_shift (cell_shift),
        .o_snap_valid (snap_valid),
        .o_busy       (busy),
        .o_done       (done),
        .o_step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters see the pre-edge values the DUT itself acts on.
    always @(posedge clk) begin
        if (cell_shift === 1'b1) nShift++;
        if (cell_reset === 1'b1) nReset++;
        if (cell_load === 1'b1) nLoad++;
        if (done === 1'b1) nDone++;
        if ((snap_valid === 1'b1) && snap_ready) nHs++;
    end

    function automatic logic [5:0] flags();
        return {cell_reset, cell_load, cell_shift, snap_valid, busy, done};
    endfunction

    task automatic addVec(input logic r, input logic s, input logic il,
                          input logic [15:0] n, input logic [5:0] ef, input logic [15:0] ec);
        vec_t v;
        v.rst_n = r; v.start = s; v.init_load = il; v.num = n;
        v.expFlags = ef; v.expCount = ec;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive inputs, let one active edge pass, then sample on the falling edge.
    task automatic applyStimulus(input vec_t v);
        rst_n     = v.rst_n;
        start     = v.start;
        init_load = v.init_load;
        num_steps = v.num;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int got;
        logic seen;
        rst_n = 1'b0; start = 1'b0; init_load = 1'b0; num_steps = '0;
        abort = 1'b0; snap_en = 1'b0; snap_ready = 1'b0;

        // flags = {cell_reset, cell_load, cell_shift, snap_valid, busy, done}
        addVec(0, 0, 0, 0, 6'b000000, 0);
        addVec(1, 0, 0, 0, 6'b000000, 0);
        // S=2, init_load, N=3
        addVec(1, 1, 1, 3, 6'b100010, 0);
        addVec(1, 0, 0, 3, 6'b010010, 0);
        addVec(1, 0, 0, 3, 6'b000010, 0);
        addVec(1, 0, 0, 3, 6'b000010, 0);
        addVec(1, 0, 0, 3, 6'b001010, 0);
        addVec(1, 0, 0, 3, 6'b000010, 1);
        addVec(1, 0, 0, 3, 6'b000010, 1);
        addVec(1, 0, 0, 3, 6'b001010, 1);
        addVec(1, 0, 0, 3, 6'b000010, 2);
        addVec(1, 0, 0, 3, 6'b000010, 2);
        addVec(1, 0, 0, 3, 6'b001010, 2);
        addVec(1, 0, 0, 3, 6'b000011, 3);
        addVec(1, 0, 0, 3, 6'b000000, 3);
        // init_load with zero steps
        addVec(1, 1, 1, 0, 6'b100010, 0);
        addVec(1, 0, 0, 0, 6'b010010, 0);
        addVec(1, 0, 0, 0, 6'b000011, 0);
        addVec(1, 0, 0, 0, 6'b000000, 0);
        // no init_load, zero steps: straight to DONE
        addVec(1, 1, 0, 0, 6'b000011, 0);
        addVec(1, 0, 0, 0, 6'b000000, 0);
        // reset after the first shift of a 5-step run
        addVec(1, 1, 0, 5, 6'b000010, 0);
        addVec(1, 0, 0, 5, 6'b000010, 0);
        addVec(1, 0, 0, 5, 6'b001010, 0);
        addVec(1, 0, 0, 5, 6'b000010, 1);
        addVec(0, 0, 0, 5, 6'b000000, 0);
        addVec(1, 0, 0, 5, 6'b000000, 0);
        addVec(1, 0, 0, 5, 6'b000000, 0);
        addVec(1, 0, 0, 5, 6'b000000, 0);
        addVec(1, 0, 0, 5, 6'b000000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].expFlags));
            checkOutput($sformatf("vec%0d_count", i), 32'(step_count), 32'(vecs[i].expCount));
        end

        // Snapshot run: N=2, readout stalls 5 cycles on the first snapshot.
        base = nShift;
        got  = nHs;
        snap_en = 1'b1; snap_ready = 1'b0; init_load = 1'b0; num_steps = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (snap_valid === 1'b1) seen = 1'b1;
            else tick();
        end
        checkOutput("snap_first_valid", 32'(seen), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput($sformatf("snap_stall%0d_valid", c), 32'(snap_valid), 32'd1);
        end
        checkOutput("snap_stall_shifts", 32'(nShift - base), 32'd1);
        snap_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput("snap_done_seen", 32'(seen), 32'd1);
        checkOutput("snap_handshakes", 32'(nHs - got), 32'd2);
        checkOutput("snap_shifts", 32'(nShift - base), 32'd2);
        checkOutput("snap_count", 32'(step_count), 32'd2);
        snap_ready = 1'b0; snap_en = 1'b0;
        tick();

        // Abort in the cycle after the second shift of a 10-step run.
        base = nShift;
        got  = nDone;
        init_load = 1'b0; num_steps = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; num_steps = 16'd1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if ((cell_shift === 1'b1) && (nShift - base == 1)) seen = 1'b1;
            else tick();
        end
        checkOutput("abort_second_shift", 32'(seen), 32'd1);
        tick();
        checkOutput("abort_in_settle_busy", 32'(busy), 32'd1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_count", 32'(step_count), 32'd2);
        for (int c = 0; c < 6; c++) tick();
        checkOutput("abort_no_done", 32'(nDone - got), 32'd0);
        checkOutput("abort_shifts", 32'(nShift - base), 32'd2);
        checkOutput("abort_idle", 32'(flags()), 32'd0);

        // Back-to-back: start held across DONE; the second run skips CLEAR/LOAD.
        init_load = 1'b1; num_steps = 16'd1; start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput("b2b_first_done", 32'(seen), 32'd1);
        checkOutput("b2b_first_count", 32'(step_count), 32'd1);
        init_load = 1'b0; num_steps = 16'd2;
        base = nShift;
        got  = nReset + nLoad;
        tick();
        checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        checkOutput("b2b_restart_flags", 32'(flags()), 32'b000010);
        checkOutput("b2b_restart_count", 32'(step_count), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        checkOutput("b2b_second_done", 32'(seen), 32'd1);
        checkOutput("b2b_second_count", 32'(step_count), 32'd2);
        checkOutput("b2b_second_shifts", 32'(nShift - base), 32'd2);
        checkOutput("b2b_no_clear_load", 32'(nReset + nLoad - got), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
